// File: rtl/sat_trunc_arb.sv
// Round-robin scheduler sharing one saturate/truncate requantizer among NUM_REQ lanes.
// One grant per cycle, one-cycle latency, with a sticky saturation-event counter.
module sat_trunc_arb #(
    parameter int NUM_REQ   = 4,
    parameter int M_I       = 1,
    parameter int N_I       = 24,
    parameter int M_O       = 1,
    parameter int N_O       = 20,
    parameter int SAT_CNT_W = 16,
    localparam int IW  = M_I + N_I,
    localparam int OW  = M_O + N_O,
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic [NUM_REQ*IW-1:0]   req_data_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic signed [OW-1:0]    out_data_o,
    output logic [IDW-1:0]          out_id_o,
    output logic                    out_sat_o,
    output logic [SAT_CNT_W-1:0]    sat_cnt_o,
    input  logic                    sat_clr_i
);

    localparam int K = M_I - M_O + 1;
    localparam logic [OW-1:0] SAT_LO = {1'b1, {(OW-1){1'b0}}};
    localparam logic [OW-1:0] SAT_HI = {1'b0, {(OW-1){1'b1}}};

    // Returns {sat, data}; in range only when the K top bits all match the sign.
    function automatic logic [OW:0] requant(input logic signed [IW-1:0] x);
        logic [K-1:0]         top;
        logic signed [OW-1:0] res;
        logic                 sat;
        top = x[IW-1 -: K];
        if ((&top) || !(|top)) begin
            res = x[N_I+M_O-1 : N_I-N_O];
            sat = 1'b0;
        end else if (x[IW-1]) begin
            res = SAT_LO;
            sat = 1'b1;
        end else begin
            res = SAT_HI;
            sat = 1'b1;
        end
        return {sat, res};
    endfunction

    logic [IDW-1:0]        ptr;
    logic [IDW-1:0]        gnt_id_p0;
    logic                  gnt_any_p0;
    logic [IDW-1:0]        lo_id;
    logic                  lo_any;
    logic [IDW-1:0]        hi_id;
    logic                  hi_any;
    logic [NUM_REQ-1:0]    gnt_oh_p0;
    logic signed [IW-1:0]  sel_p0;
    logic signed [OW-1:0]  qdata_p0;
    logic                  qsat_p0;
    logic                  slot_free;
    logic                  xfer_p0;
    logic [IDW-1:0]        ptr_nxt;

    // Stage p0: arbitration, operand select and requantization
    always_comb begin
        lo_id  = '0;
        lo_any = 1'b0;
        hi_id  = '0;
        hi_any = 1'b0;
        // Descending scan so the lowest matching index is left standing.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[k]) begin
                lo_id  = IDW'(k);
                lo_any = 1'b1;
                if (IDW'(k) >= ptr) begin
                    hi_id  = IDW'(k);
                    hi_any = 1'b1;
                end
            end
        end
        gnt_any_p0 = lo_any;
        gnt_id_p0  = hi_any ? hi_id : lo_id;
    end

    always_comb begin
        gnt_oh_p0 = '0;
        sel_p0    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            gnt_oh_p0[k] = gnt_any_p0 && (gnt_id_p0 == IDW'(k));
            if (gnt_id_p0 == IDW'(k)) sel_p0 = req_data_i[k*IW +: IW];
        end
    end

    generate
        if (N_I > N_O) begin : g_lsb_sink
            logic unused_lsb;
            assign unused_lsb = ^sel_p0[N_I-N_O-1:0];
        end
    endgenerate

    assign {qsat_p0, qdata_p0} = requant(sel_p0);
    assign slot_free   = !out_valid_o || out_ready_i;
    assign req_ready_o = slot_free ? gnt_oh_p0 : '0;
    assign xfer_p0     = slot_free && gnt_any_p0;
    assign ptr_nxt     = (gnt_id_p0 == IDW'(NUM_REQ - 1)) ? '0 : gnt_id_p0 + 1'b1;

    // Stage p1: registered output slot, pointer and saturation counter
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_id_o    <= '0;
            out_sat_o   <= 1'b0;
            ptr         <= '0;
            sat_cnt_o   <= '0;
        end else begin
            if (xfer_p0) begin
                out_valid_o <= 1'b1;
                out_data_o  <= qdata_p0;
                out_id_o    <= gnt_id_p0;
                out_sat_o   <= qsat_p0;
                ptr         <= ptr_nxt;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end

            if (sat_clr_i) begin
                sat_cnt_o <= '0;
            end else if (xfer_p0 && qsat_p0 && (sat_cnt_o != {SAT_CNT_W{1'b1}})) begin
                sat_cnt_o <= sat_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sat_trunc_arb.sv
// Directed bench for sat_trunc_arb: 4 requesters, 12-bit Q4.8 in, 6-bit Q2.4 out, 3-bit counter.
module tb_sat_trunc_arb;

    localparam int NUM_REQ = 4;
    localparam int M_I = 4;
    localparam int N_I = 8;
    localparam int M_O = 2;
    localparam int N_O = 4;
    localparam int SCW = 3;
    localparam int IW  = M_I + N_I;
    localparam int OW  = M_O + N_O;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*IW-1:0] req_data;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [OW-1:0]  out_data;
    logic [1:0]            out_id;
    logic                  out_sat;
    logic [SCW-1:0]        sat_cnt;
    logic                  sat_clr;

    int n_checks = 0;
    int n_fail   = 0;

    sat_trunc_arb #(
        .NUM_REQ(NUM_REQ), .M_I(M_I), .N_I(N_I), .M_O(M_O), .N_O(N_O), .SAT_CNT_W(SCW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_id_o(out_id), .out_sat_o(out_sat),
        .sat_cnt_o(sat_cnt), .sat_clr_i(sat_clr)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int k, input logic [IW-1:0] v);
        req_data[k*IW +: IW] = v;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; req_valid = '0; sat_clr = 1'b0; out_ready = 1'b1;
        tick; tick;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = '0; sat_clr = 1'b0; out_ready = 1'b1; req_data = '0;
        tick; tick;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", out_valid); end
        n_checks++; if (out_data !== 6'h00) begin n_fail++; $display("FAIL rst_data got %h want 00", out_data); end
        n_checks++; if (out_id !== 2'd0) begin n_fail++; $display("FAIL rst_id got %0d want 0", out_id); end
        n_checks++; if (out_sat !== 1'b0) begin n_fail++; $display("FAIL rst_sat got %b want 0", out_sat); end
        n_checks++; if (sat_cnt !== 3'd0) begin n_fail++; $display("FAIL rst_cnt got %0d want 0", sat_cnt); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready got %b want 0000", req_ready); end
        rst_n = 1'b1;
        req_valid = 4'b0100; set_data(2, 12'h038);
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL first_ready got %b want 0100", req_ready); end
        tick;
        req_valid = '0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid got %b want 1", out_valid); end
        n_checks++; if (out_data !== 6'h03) begin n_fail++; $display("FAIL first_data got %h want 03", out_data); end
        n_checks++; if (out_id !== 2'd2) begin n_fail++; $display("FAIL first_id got %0d want 2", out_id); end
        n_checks++; if (out_sat !== 1'b0) begin n_fail++; $display("FAIL first_sat got %b want 0", out_sat); end
        tick;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid got %b want 0", out_valid); end
        n_checks++; if (out_data !== 6'h03) begin n_fail++; $display("FAIL drain_hold got %h want 03", out_data); end
    endtask

    task automatic test_requant;
        logic [IW-1:0] vin  [4] = '{12'h7FF, 12'h800, 12'hE80, 12'h1F0};
        logic [OW-1:0] vout [4] = '{6'h1F, 6'h20, 6'h28, 6'h1F};
        logic          vsat [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        do_reset;
        for (int i = 0; i < 4; i++) begin
            req_valid = 4'b0001; set_data(0, vin[i]);
            tick;
            req_valid = '0;
            n_checks++; if (out_data !== vout[i]) begin n_fail++; $display("FAIL rq_data[%0d] got %h want %h", i, out_data, vout[i]); end
            n_checks++; if (out_sat !== vsat[i]) begin n_fail++; $display("FAIL rq_sat[%0d] got %b want %b", i, out_sat, vsat[i]); end
            tick;
        end
        n_checks++; if (sat_cnt !== 3'd2) begin n_fail++; $display("FAIL rq_cnt got %0d want 2", sat_cnt); end
    endtask

    task automatic test_fairness;
        logic [1:0] exp_id;
        do_reset;
        for (int k = 0; k < NUM_REQ; k++) set_data(k, 12'((k + 1) << 4));
        req_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            tick;
            exp_id = 2'(i % 4);
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d] got %b want 1", i, out_valid); end
            n_checks++; if (out_id !== exp_id) begin n_fail++; $display("FAIL rr_id[%0d] got %0d want %0d", i, out_id, exp_id); end
            n_checks++; if (out_data !== 6'(exp_id + 1)) begin n_fail++; $display("FAIL rr_data[%0d] got %h want %h", i, out_data, 6'(exp_id + 1)); end
        end
        req_valid = '0;
        tick;
    endtask

    task automatic test_backpressure;
        do_reset;
        set_data(1, 12'h050); set_data(3, 12'h0A0);
        req_valid = 4'b1010;
        tick;
        req_valid = 4'b1000;
        out_ready = 1'b0;
        #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready0 got %b want 0000", req_ready); end
        for (int i = 0; i < 5; i++) begin
            tick;
            n_checks++; if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== 6'h05) begin
                n_fail++; $display("FAIL bp_hold[%0d] got v%b id%0d d%h want v1 id1 d05", i, out_valid, out_id, out_data);
            end
            n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d] got %b want 0000", i, req_ready); end
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_release got %b want 1000", req_ready); end
        tick;
        req_valid = '0;
        n_checks++; if (out_valid !== 1'b1 || out_id !== 2'd3 || out_data !== 6'h0A) begin
            n_fail++; $display("FAIL bp_next got v%b id%0d d%h want v1 id3 d0A", out_valid, out_id, out_data);
        end
        tick;
    endtask

    task automatic test_counter;
        logic [2:0] exp_cnt;
        do_reset;
        req_valid = 4'b0001; set_data(0, 12'h7FF);
        for (int i = 0; i < 9; i++) begin
            tick;
            exp_cnt = (i + 1 > 7) ? 3'd7 : 3'(i + 1);
            n_checks++; if (sat_cnt !== exp_cnt) begin n_fail++; $display("FAIL cnt[%0d] got %0d want %0d", i, sat_cnt, exp_cnt); end
        end
        sat_clr = 1'b1;
        tick;
        sat_clr = 1'b0; req_valid = '0;
        n_checks++; if (sat_cnt !== 3'd0) begin n_fail++; $display("FAIL cnt_clr got %0d want 0", sat_cnt); end
        n_checks++; if (out_sat !== 1'b1) begin n_fail++; $display("FAIL cnt_clr_sat got %b want 1", out_sat); end
        tick;
        n_checks++; if (sat_cnt !== 3'd0) begin n_fail++; $display("FAIL cnt_after got %0d want 0", sat_cnt); end
    endtask

    task automatic test_midreset;
        do_reset;
        for (int k = 0; k < NUM_REQ; k++) set_data(k, 12'((k + 1) << 4));
        req_valid = 4'b0010;
        tick;
        n_checks++; if (out_valid !== 1'b1 || out_id !== 2'd1) begin
            n_fail++; $display("FAIL mr_pre got v%b id%0d want v1 id1", out_valid, out_id);
        end
        rst_n = 1'b0; req_valid = 4'b1111;
        tick;
        n_checks++; if (out_valid !== 1'b0 || out_id !== 2'd0 || out_data !== 6'h00) begin
            n_fail++; $display("FAIL mr_rst got v%b id%0d d%h want v0 id0 d00", out_valid, out_id, out_data);
        end
        rst_n = 1'b1;
        tick;
        n_checks++; if (out_valid !== 1'b1 || out_id !== 2'd0) begin
            n_fail++; $display("FAIL mr_first got v%b id%0d want v1 id0", out_valid, out_id);
        end
        tick;
        n_checks++; if (out_id !== 2'd1) begin n_fail++; $display("FAIL mr_second got %0d want 1", out_id); end
        req_valid = '0;
        tick;
    endtask

    initial begin
        test_reset;
        test_requant;
        test_fairness;
        test_backpressure;
        test_counter;
        test_midreset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sat_trunc_arb.md
Name: sat_trunc_arb

Overview:
Round-robin scheduler that shares one fixed-point saturate/truncate requantizer among NUM_REQ requesters.
- Each requester presents a Q(M_I).(N_I) sample on a valid/ready handshake.
- The block grants one requester per cycle, requantizes the sample to Q(M_O).(N_O), and registers the result with its source ID and a saturation flag.
- Sits between parallel filter/accumulator lanes and a single narrower downstream consumer.
- Keeps a saturation-event counter for status readback.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
M_I, 1, input integer bits incl. sign
N_I, 24, input fractional bits
M_O, 1, output integer bits incl. sign (M_O <= M_I)
N_O, 20, output fractional bits (N_O <= N_I)
SAT_CNT_W, 16, saturation counter width

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
req_valid_i  in  NUM_REQ  per-requester sample valid
req_ready_o  out  NUM_REQ  per-requester accept (one-hot or zero)
req_data_i  in  NUM_REQ*(M_I+N_I)  packed signed samples; requester k at slice k
out_valid_o  out  1  requantized sample valid
out_ready_i  in  1  downstream accept
out_data_o  out  M_O+N_O  requantized signed sample
out_id_o  out  clog2(NUM_REQ) (min 1)  source requester index
out_sat_o  out  1  sample was saturated
sat_cnt_o  out  SAT_CNT_W  saturation events since reset/clear
sat_clr_i  in  1  synchronous clear of sat_cnt_o

Behaviour:
- Reset (rst_ni=0 at a clk_i edge):
  - out_valid_o=0, out_data_o=0, out_id_o=0, out_sat_o=0, sat_cnt_o=0.
  - Round-robin pointer=0.
  - Any in-flight output is discarded.
- Slot free: slot_free = !out_valid_o || out_ready_i.
- Arbitration, combinational in the same cycle:
  - Grant the first requester with req_valid_i=1, searching from the pointer upward with wrap.
  - req_ready_o = one-hot grant when slot_free, else all zero.
  - No grant when no requester is valid.
- Transfer: occurs when req_valid_i[g] && req_ready_o[g]. On the next edge:
  - out_valid_o=1; out_data_o/out_id_o/out_sat_o are loaded.
  - pointer = (g+1) mod NUM_REQ.
- Pointer holds when no transfer occurs.
- Latency: exactly 1 cycle from accept to out_valid_o.
- Throughput: 1 sample/cycle while out_ready_i=1.
- Output hold: out_valid_o=1 && out_ready_i=0 holds all out_* stable and keeps every req_ready_o at 0.
- Output drain: out_ready_i=1 with no transfer clears out_valid_o on the next edge; data fields hold their old value.
- Simultaneous drain and accept: new sample loads with no bubble.
- Requantization, with K = M_I-M_O+1 top input bits:
  - In range: all K bits equal. out_data = input bits [N_I+M_O-1 : N_I-N_O], i.e. truncation toward -inf; out_sat=0.
  - Out of range, sign bit 1: out_data = SAT_LO = 1 followed by M_O+N_O-1 zeros; out_sat=1.
  - Out of range, sign bit 0: out_data = SAT_HI = 0 followed by M_O+N_O-1 ones; out_sat=1.
  - No rounding.
- Saturation counter:
  - Increments by 1 on each accepted sample that saturates.
  - Sticks at all-ones, no wrap.
  - sat_clr_i=1 sets it to 0 on the next edge; clear wins over a simultaneous increment.
- Requester protocol:
  - Requester holds valid and data until accepted.
  - Block does not check protocol violations.
  - Deasserting valid without acceptance simply drops that requester from arbitration.

Test Plan:
Params NUM_REQ=4, M_I=4, N_I=8, M_O=2, N_O=4 (12-bit in, 6-bit out).
1. Reset then idle: rst_ni=0 for 2 cycles -> all outputs 0, req_ready_o=0000. Then a single valid on req 2, data 0x038 -> req_ready_o=0100 same cycle; next cycle out_valid_o=1, out_data_o=0x03, out_id_o=2, out_sat_o=0.
2. Requantization corners, one at a time on req 0:
   - 0x7FF -> 0x1F, sat=1
   - 0x800 -> 0x20, sat=1
   - 0xE80 -> 0x28, sat=0
   - 0x1F0 -> 0x1F, sat=0
   - sat_cnt_o=2 at the end.
3. Fairness: all four valid continuously, out_ready_i=1 -> out_id_o sequence 0,1,2,3,0,1 on back-to-back cycles, no bubbles.
4. Backpressure: out_ready_i=0 for 5 cycles with reqs 1 and 3 valid -> out_* frozen and req_ready_o=0000. On release, req 1 is consumed and req 3 granted in the same cycle; output 3 follows next cycle.
5. Counter saturation/clear: with SAT_CNT_W=3, feed 9 saturating samples -> sat_cnt_o stops at 7. Assert sat_clr_i on the same cycle as a saturating accept -> sat_cnt_o=0.
6. Mid-stream reset: pull rst_ni low while out_valid_o=1 and the pointer is at 2 -> next edge out_valid_o=0. After release, all-valid requests are granted starting at req 0.
